// File: rtl/syzygy_dac_spi_arbiter_if.sv
// Requester-side bundle for the SZG-DAC SPI arbiter: one instance per requester.
// master = requester (power-up controller or host path), slave = arbiter.
interface syzygy_dac_spi_arbiter_if;
    logic       req;
    logic [5:0] reg_addr;
    logic [7:0] wdata;
    logic       rw;
    logic       done;
    logic [7:0] rdata;
    logic       err;

    modport master (output req, reg_addr, wdata, rw, input done, rdata, err);
    modport slave  (input req, reg_addr, wdata, rw, output done, rdata, err);
endinterface

// File: rtl/syzygy_dac_spi_arbiter.sv
// Shares one SZG-DAC SPI engine between two requesters (R0 power-up, R1 host),
// with fixed-priority or round-robin tie-break and a hung-engine timeout.
module syzygy_dac_spi_arbiter #(
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    syzygy_dac_spi_arbiter_if.slave        r0,
    syzygy_dac_spi_arbiter_if.slave        r1,
    output logic [5:0]                     spi_reg,
    output logic [7:0]                     spi_data_in,
    output logic                           spi_rw,
    output logic                           spi_send,
    input  logic                           spi_done,
    input  logic [7:0]                     spi_data_out,
    output logic                           busy,
    output logic                           grant,
    output logic                           timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic        last_grant_r, last_grant_s;
    logic        grant_r, grant_s;
    logic        busy_r, busy_s;
    logic [5:0]  spi_reg_r, spi_reg_s;
    logic [7:0]  spi_data_in_r, spi_data_in_s;
    logic        spi_rw_r, spi_rw_s;
    logic        spi_send_r, spi_send_s;
    logic        r0_done_r, r0_done_s, r1_done_r, r1_done_s;
    logic [7:0]  r0_rdata_r, r0_rdata_s, r1_rdata_r, r1_rdata_s;
    logic        r0_err_r, r0_err_s, r1_err_r, r1_err_s;
    logic        timeout_flag_r, timeout_flag_s;
    logic        pick_r1_s;

    // Tie-break: round-robin hands a tie to whoever did not own the last transaction.
    always_comb begin
        pick_r1_s = 1'b0;
        if (r0.req && r1.req) begin
            pick_r1_s = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_r;
        end else begin
            pick_r1_s = r1.req;
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        last_grant_s   = last_grant_r;
        grant_s        = grant_r;
        spi_reg_s      = spi_reg_r;
        spi_data_in_s  = spi_data_in_r;
        spi_rw_s       = spi_rw_r;
        spi_send_s     = 1'b0;
        r0_done_s      = 1'b0;
        r1_done_s      = 1'b0;
        r0_rdata_s     = r0_rdata_r;
        r1_rdata_s     = r1_rdata_r;
        r0_err_s       = r0_err_r;
        r1_err_s       = r1_err_r;
        timeout_flag_s = timeout_flag_r;
        case (state_r)
            ST_IDLE: begin
                if (r0.req || r1.req) begin
                    state_s       = ST_ISSUE;
                    grant_s       = pick_r1_s;
                    last_grant_s  = pick_r1_s;
                    spi_reg_s     = pick_r1_s ? r1.reg_addr : r0.reg_addr;
                    spi_data_in_s = pick_r1_s ? r1.wdata    : r0.wdata;
                    spi_rw_s      = pick_r1_s ? r1.rw       : r0.rw;
                    spi_send_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
                cnt_s   = 16'd0;
            end
            ST_WAIT: begin
                // A completion on the timeout cycle still counts as success.
                if (spi_done) begin
                    state_s = ST_DONE;
                    if (grant_r) begin
                        r1_rdata_s = spi_data_out;
                        r1_err_s   = 1'b0;
                        r1_done_s  = 1'b1;
                    end else begin
                        r0_rdata_s = spi_data_out;
                        r0_err_s   = 1'b0;
                        r0_done_s  = 1'b1;
                    end
                end else if (cnt_r == TO_LAST) begin
                    state_s        = ST_DONE;
                    timeout_flag_s = 1'b1;
                    if (grant_r) begin
                        r1_rdata_s = 8'hFF;
                        r1_err_s   = 1'b1;
                        r1_done_s  = 1'b1;
                    end else begin
                        r0_rdata_s = 8'hFF;
                        r0_err_s   = 1'b1;
                        r0_done_s  = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 16'd0;
            last_grant_r   <= 1'b1;
            grant_r        <= 1'b0;
            busy_r         <= 1'b0;
            spi_reg_r      <= 6'd0;
            spi_data_in_r  <= 8'd0;
            spi_rw_r       <= 1'b0;
            spi_send_r     <= 1'b0;
            r0_done_r      <= 1'b0;
            r1_done_r      <= 1'b0;
            r0_rdata_r     <= 8'd0;
            r1_rdata_r     <= 8'd0;
            r0_err_r       <= 1'b0;
            r1_err_r       <= 1'b0;
            timeout_flag_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            last_grant_r   <= last_grant_s;
            grant_r        <= grant_s;
            busy_r         <= busy_s;
            spi_reg_r      <= spi_reg_s;
            spi_data_in_r  <= spi_data_in_s;
            spi_rw_r       <= spi_rw_s;
            spi_send_r     <= spi_send_s;
            r0_done_r      <= r0_done_s;
            r1_done_r      <= r1_done_s;
            r0_rdata_r     <= r0_rdata_s;
            r1_rdata_r     <= r1_rdata_s;
            r0_err_r       <= r0_err_s;
            r1_err_r       <= r1_err_s;
            timeout_flag_r <= timeout_flag_s;
        end
    end

    assign spi_reg      = spi_reg_r;
    assign spi_data_in  = spi_data_in_r;
    assign spi_rw       = spi_rw_r;
    assign spi_send     = spi_send_r;
    assign busy         = busy_r;
    assign grant        = grant_r;
    assign timeout_flag = timeout_flag_r;
    assign r0.done      = r0_done_r;
    assign r0.rdata     = r0_rdata_r;
    assign r0.err       = r0_err_r;
    assign r1.done      = r1_done_r;
    assign r1.rdata     = r1_rdata_r;
    assign r1.err       = r1_err_r;

endmodule

// File: tb/tb_syzygy_dac_spi_arbiter.sv
// Directed bench: a round-robin arbiter and a fixed-priority twin share stimulus and a
// hand-driven engine; expected values are written out per vector.
module tb_syzygy_dac_spi_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_done;
    logic [7:0] spi_data_out;
    logic [5:0] spi_reg, fp_spi_reg;
    logic [7:0] spi_data_in, fp_spi_data_in;
    logic       spi_rw, fp_spi_rw, spi_send, fp_spi_send;
    logic       busy, fp_busy, grant, fp_grant, timeout_flag, fp_timeout_flag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    syzygy_dac_spi_arbiter_if r0_if ();
    syzygy_dac_spi_arbiter_if r1_if ();
    syzygy_dac_spi_arbiter_if r0f_if ();
    syzygy_dac_spi_arbiter_if r1f_if ();

    assign r0f_if.req      = r0_if.req;
    assign r0f_if.reg_addr = r0_if.reg_addr;
    assign r0f_if.wdata    = r0_if.wdata;
    assign r0f_if.rw       = r0_if.rw;
    assign r1f_if.req      = r1_if.req;
    assign r1f_if.reg_addr = r1_if.reg_addr;
    assign r1f_if.wdata    = r1_if.wdata;
    assign r1f_if.rw       = r1_if.rw;

    syzygy_dac_spi_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .r0(r0_if.slave), .r1(r1_if.slave),
        .spi_reg(spi_reg), .spi_data_in(spi_data_in), .spi_rw(spi_rw),
        .spi_send(spi_send), .spi_done(spi_done), .spi_data_out(spi_data_out),
        .busy(busy), .grant(grant), .timeout_flag(timeout_flag)
    );

    syzygy_dac_spi_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYC(16)) dut_fp (
        .clk(clk), .reset(reset), .r0(r0f_if.slave), .r1(r1f_if.slave),
        .spi_reg(fp_spi_reg), .spi_data_in(fp_spi_data_in), .spi_rw(fp_spi_rw),
        .spi_send(fp_spi_send), .spi_done(spi_done), .spi_data_out(spi_data_out),
        .busy(fp_busy), .grant(fp_grant), .timeout_flag(fp_timeout_flag)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from requester 'who'; engine answers lat+1 cycles after ISSUE.
    task automatic do_txn(input logic who, input logic [5:0] a, input logic [7:0] wd,
                          input logic rw, input int lat, input logic [7:0] ed, input string tag);
        tick();
        if (who) begin
            r1_if.req = 1'b1; r1_if.reg_addr = a; r1_if.wdata = wd; r1_if.rw = rw;
        end else begin
            r0_if.req = 1'b1; r0_if.reg_addr = a; r0_if.wdata = wd; r0_if.rw = rw;
        end
        @(negedge clk);
        check_eq({tag, ".send_arb"}, 16'(spi_send), 16'd0);
        tick();
        @(negedge clk);
        check_eq({tag, ".send"},  16'(spi_send), 16'd1);
        check_eq({tag, ".reg"},   16'(spi_reg), 16'(a));
        check_eq({tag, ".wdata"}, 16'(spi_data_in), 16'(wd));
        check_eq({tag, ".rw"},    16'(spi_rw), 16'(rw));
        check_eq({tag, ".grant"}, 16'(grant), 16'(who));
        check_eq({tag, ".busy"},  16'(busy), 16'd1);
        repeat (lat + 1) tick();
        spi_done = 1'b1; spi_data_out = ed;
        @(negedge clk);
        check_eq({tag, ".done_early"}, 16'({r1_if.done, r0_if.done}), 16'd0);
        tick();
        spi_done = 1'b0; spi_data_out = 8'h00;
        @(negedge clk);
        check_eq({tag, ".done"},  16'({r1_if.done, r0_if.done}), who ? 16'd2 : 16'd1);
        check_eq({tag, ".rdata"}, 16'(who ? r1_if.rdata : r0_if.rdata), 16'(ed));
        check_eq({tag, ".err"},   16'(who ? r1_if.err : r0_if.err), 16'd0);
        if (who) r1_if.req = 1'b0; else r0_if.req = 1'b0;
        tick();
        @(negedge clk);
        check_eq({tag, ".idle"}, 16'({busy, r1_if.done, r0_if.done}), 16'd0);
    endtask

    initial begin
        reset = 1'b1; spi_done = 1'b0; spi_data_out = 8'h00;
        r0_if.req = 1'b0; r0_if.reg_addr = 6'd0; r0_if.wdata = 8'd0; r0_if.rw = 1'b0;
        r1_if.req = 1'b0; r1_if.reg_addr = 6'd0; r1_if.wdata = 8'd0; r1_if.rw = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst.busy",  16'(busy), 16'd0);
        check_eq("rst.grant", 16'(grant), 16'd0);
        check_eq("rst.spi",   16'({spi_send, spi_rw, spi_reg}), 16'd0);
        check_eq("rst.data",  16'(spi_data_in), 16'd0);
        check_eq("rst.done",  16'({r1_if.done, r0_if.done, r1_if.err, r0_if.err}), 16'd0);
        check_eq("rst.flag",  16'(timeout_flag), 16'd0);
        tick();
        reset = 1'b0;

        do_txn(1'b0, 6'h02, 8'h5A, 1'b0, 2, 8'h00, "r0wr");
        do_txn(1'b1, 6'h15, 8'h00, 1'b1, 3, 8'hC3, "r1rd");
        check_eq("r1rd.r0_rdata_held", 16'(r0_if.rdata), 16'h00);

        // Tie rounds: both requests held; last owner was R1 so RR starts with R0.
        tick();
        r0_if.req = 1'b1; r0_if.reg_addr = 6'h01; r0_if.rw = 1'b0; r0_if.wdata = 8'h10;
        r1_if.req = 1'b1; r1_if.reg_addr = 6'h11; r1_if.rw = 1'b1; r1_if.wdata = 8'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check_eq($sformatf("rr%0d.grant", k), 16'(grant), 16'(k % 2));
            check_eq($sformatf("rr%0d.reg", k), 16'(spi_reg), (k % 2) ? 16'h11 : 16'h01);
            check_eq($sformatf("fp%0d.grant", k), 16'(fp_grant), 16'd0);
            check_eq($sformatf("fp%0d.reg", k), 16'(fp_spi_reg), 16'h01);
            tick();
            spi_done = 1'b1; spi_data_out = 8'h40 + 8'(k);
            tick();
            spi_done = 1'b0;
            @(negedge clk);
            check_eq($sformatf("rr%0d.done", k), 16'({r1_if.done, r0_if.done}), (k % 2) ? 16'd2 : 16'd1);
            check_eq($sformatf("fp%0d.done", k), 16'({r1f_if.done, r0f_if.done}), 16'd1);
            if (k == 3) begin
                r0_if.req = 1'b0; r1_if.req = 1'b0;
            end
            tick();
        end
        check_eq("rr.r0_rdata", 16'(r0_if.rdata), 16'h42);
        check_eq("rr.r1_rdata", 16'(r1_if.rdata), 16'h43);

        // spi_done on the very cycle the counter would expire: success, no flag.
        do_txn(1'b0, 6'h05, 8'h11, 1'b0, 15, 8'h77, "edge");
        check_eq("edge.flag", 16'(timeout_flag), 16'd0);

        // Engine never answers: done at ISSUE+17 with error.
        tick();
        r0_if.req = 1'b1; r0_if.reg_addr = 6'h08; r0_if.wdata = 8'h22; r0_if.rw = 1'b1;
        tick();
        @(negedge clk);
        check_eq("to.send", 16'(spi_send), 16'd1);
        repeat (16) tick();
        @(negedge clk);
        check_eq("to.not_yet", 16'({busy, r0_if.done}), 16'd2);
        tick();
        @(negedge clk);
        check_eq("to.done",  16'({r1_if.done, r0_if.done}), 16'd1);
        check_eq("to.err",   16'(r0_if.err), 16'd1);
        check_eq("to.rdata", 16'(r0_if.rdata), 16'hFF);
        check_eq("to.flag",  16'(timeout_flag), 16'd1);
        r0_if.req = 1'b0;
        tick();
        spi_done = 1'b1; spi_data_out = 8'hAB;
        @(negedge clk);
        check_eq("late.busy", 16'(busy), 16'd0);
        tick();
        spi_done = 1'b0; spi_data_out = 8'h00;
        @(negedge clk);
        check_eq("late.ignored", 16'({busy, spi_send, r1_if.done, r0_if.done}), 16'd0);
        check_eq("late.rdata",   16'(r0_if.rdata), 16'hFF);
        check_eq("late.flag",    16'(timeout_flag), 16'd1);
        do_txn(1'b1, 6'h3F, 8'hA5, 1'b0, 1, 8'h00, "after_to");
        check_eq("after_to.flag", 16'(timeout_flag), 16'd1);

        // Reset while waiting on the engine: abort silently.
        tick();
        r0_if.req = 1'b1; r0_if.reg_addr = 6'h01;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; r0_if.req = 1'b0;
        @(negedge clk);
        check_eq("rstw.state", 16'({busy, spi_send, r1_if.done, r0_if.done}), 16'd0);
        check_eq("rstw.flag",  16'(timeout_flag), 16'd0);
        tick();
        @(negedge clk);
        check_eq("rstw.no_done", 16'({busy, r1_if.done, r0_if.done}), 16'd0);
        do_txn(1'b1, 6'h2A, 8'h00, 1'b1, 0, 8'h3C, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
